vr_rr_arbiter: RTL and testbench
================================

Name: vr_rr_arbiter

Overview:
- Shares one valid-ready output channel among NUM_REQ valid-ready requesters.
- Arbitration is round-robin and packet-locked: once a requester wins, it owns the channel until its Last beat is accepted.
- The output is a single registered pipe stage. It uses the same ready rule as the team's middle pipe stage: ready = DataOutRdy or output stage empty.
- The block sits ahead of a shared downstream pipe or resource that accepts one stream at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- DW, 8, data width per beat.
- IW, max(1, clog2(NUM_REQ)), source-ID width; localparam, not overridable.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Clear  in  1  synchronous flush; same effect as Rst; Rst has priority.
- ReqData  in  NUM_REQ*DW  requester data; requester i occupies bits [i*DW +: DW].
- ReqVld  in  NUM_REQ  per-requester valid.
- ReqLast  in  NUM_REQ  per-requester end-of-packet flag, qualified by ReqVld.
- ReqRdy  out  NUM_REQ  per-requester ready; combinational.
- DataOut  out  DW  registered output data.
- DataOutSrc  out  IW  index of the requester that produced the current output beat.
- DataOutLast  out  1  registered end-of-packet flag.
- DataOutVld  out  1  registered output valid.
- DataOutRdy  in  1  downstream ready.
- Busy  out  1  high while in state LOCKED.

Behaviour:
- Reset (Rst or Clear at a clock edge) sets:
  - DataOut = 0, DataOutSrc = 0, DataOutLast = 0, DataOutVld = 0;
  - state = IDLE, round-robin pointer = 0, owner = 0.
  - ReqRdy is 0 whenever DataOutVld = 1 and DataOutRdy = 0.
- Reset mid-packet drops the packet. The partial packet is not completed, and the next winner starts cleanly.
- Stage ready: stg_rdy = DataOutRdy or ~DataOutVld.
- State IDLE:
  - sel = first i with ReqVld[i] = 1, scanning from the pointer upward and wrapping modulo NUM_REQ.
  - ReqRdy[sel] = stg_rdy; all other ReqRdy = 0. If no ReqVld is high, all ReqRdy = 0.
  - On accept (ReqVld[sel] and ReqRdy[sel]), if ReqLast[sel] = 1 (single-beat packet): stay IDLE, pointer = (sel+1) mod NUM_REQ.
  - On accept with ReqLast[sel] = 0: go to LOCKED, owner = sel; the pointer is unchanged.
- State LOCKED:
  - ReqRdy[owner] = stg_rdy; all other ReqRdy = 0.
  - When ReqVld[owner] = 0, the channel idles and the lock is held indefinitely; there is no timeout.
  - On accept with ReqLast[owner] = 1: go to IDLE, pointer = (owner+1) mod NUM_REQ.
- Output stage, evaluated when stg_rdy = 1:
  - DataOutVld <= 1 if a beat is accepted this cycle, else 0.
  - On accept, DataOut, DataOutSrc and DataOutLast load the accepted beat.
  - When stg_rdy = 0, all outputs hold their values.
  - Data fields hold their value when no beat is accepted.
- Latency: one cycle from input accept to DataOutVld.
- Throughput: one beat per cycle with back-to-back packets and no bubble. The IDLE pick is combinational, so the first beat of the next packet can be accepted in the cycle after the previous Last.
- Simultaneous events:
  - Last accepted while DataOutRdy drains the previous beat is one normal transfer.
  - Requests from non-owners during LOCKED wait; they are never dropped.
- NUM_REQ = 1 degenerates to a pass-through pipe stage with DataOutSrc = 0.
- Requester contract: requesters must hold ReqData, ReqLast and ReqVld stable until accepted. The bench asserts this; the RTL does not check it.

Decomposition:
- Shared package vr_arb_pkg holds:
  - state enum {IDLE, LOCKED};
  - a clog2-based ID-width function (minimum 1).
- Sub-module vr_rr_pick is combinational:
  - inputs: request vector and pointer;
  - outputs: one-hot grant, encoded index and any-valid flag.
  - It is reusable by other schedulers.
- The top level holds the state register, owner, pointer and output stage.

Test Plan:
- Single-beat round-robin: NUM_REQ=4, all ReqVld=1, ReqLast=1, DataOutRdy=1 -> DataOutSrc sequence 0,1,2,3,0; DataOutVld continuous from cycle 1 after reset.
- Packet lock: req0 sends 3 beats (Last on the 3rd) while req1 is valid -> DataOutSrc = 0,0,0,1; ReqRdy[1] = 0 until req0's Last is accepted.
- Backpressure: DataOutRdy=0 for 5 cycles with DataOutVld=1 -> DataOut, DataOutSrc and DataOutLast held; ReqRdy all 0; no beat lost or duplicated after release.
- Owner stall: req2 holds ReqVld=0 for 4 cycles mid-packet while req3 is valid -> Busy=1, no req3 beats issued, req2 packet completes first, then src 3.
- Sync reset/Clear mid-packet: Clear pulsed in LOCKED with a beat in the stage -> next cycle DataOutVld=0, Busy=0, pointer=0; a new req1 packet is accepted immediately.
- Pointer wrap: pointer=3 and ReqVld=4'b1001 -> req3 granted first, then req0; pointer returns to 1 after req0's Last.

Source files
------------

// File: rtl/vr_arb_pkg.sv
// Shared definitions for the valid-ready round-robin arbiter and its picker.
package vr_arb_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   typedef enum logic [0:0] {
      IDLE   = ST_IDLE,
      LOCKED = ST_LOCKED
   } arb_state_e;

   // Source-ID width; a single requester still gets a 1-bit ID.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vr_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module vr_rr_pick
   import vr_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = id_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   localparam int NS = 2**IW;

   // Padded to a power of two so an IW-bit index never leaves the vector.
   logic [NS-1:0] req_ext;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
   end

   always_comb begin
      int j;
      logic [IW-1:0] cand;
      idx  = '0;
      any  = 1'b0;
      j    = 0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         j    = (int'(ptr) + k) % N;
         cand = j[IW-1:0];
         if (!any && req_ext[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = any && (idx == IW'(i));
      end
   end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered valid-ready stage.
//   state  | meaning
//   IDLE   | no packet in flight; picker chooses from pointer upward
//   LOCKED | owner holds the channel until its Last beat is accepted
module vr_rr_arbiter
   import vr_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DW      = 8,
   localparam int IW      = id_width(NUM_REQ)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Clear,
   input  logic [NUM_REQ*DW-1:0] ReqData,
   input  logic [NUM_REQ-1:0]    ReqVld,
   input  logic [NUM_REQ-1:0]    ReqLast,
   output logic [NUM_REQ-1:0]    ReqRdy,
   output logic [DW-1:0]         DataOut,
   output logic [IW-1:0]         DataOutSrc,
   output logic                  DataOutLast,
   output logic                  DataOutVld,
   input  logic                  DataOutRdy,
   output logic                  Busy
);

   localparam int NS = 2**IW;

   arb_state_e state;
   logic [IW-1:0] ptr, owner, pick_idx, sel, ptr_next;
   logic [NUM_REQ-1:0] pick_grant, owner_hot;
   logic pick_any, stg_rdy, sel_vld, sel_last, accept;
   logic [NS-1:0] vld_ext, last_ext;
   logic [DW-1:0] data_arr [NS];

   for (genvar g = 0; g < NS; g++) begin : g_ext
      if (g < NUM_REQ) begin : g_real
         assign data_arr[g] = ReqData[g*DW +: DW];
         assign vld_ext[g]  = ReqVld[g];
         assign last_ext[g] = ReqLast[g];
      end else begin : g_pad
         assign data_arr[g] = '0;
         assign vld_ext[g]  = 1'b0;
         assign last_ext[g] = 1'b0;
      end
   end

   vr_rr_pick #(.N(NUM_REQ)) u_pick (
      .req   (ReqVld),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign stg_rdy  = DataOutRdy | ~DataOutVld;
   assign Busy     = (state == LOCKED);
   assign sel      = Busy ? owner : pick_idx;
   assign sel_vld  = Busy ? vld_ext[owner] : pick_any;
   assign sel_last = last_ext[sel];
   assign accept   = sel_vld & stg_rdy;
   assign ptr_next = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);

   always_comb begin
      owner_hot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_hot[i] = (owner == IW'(i));
      end
   end

   assign ReqRdy = (Busy ? owner_hot : pick_grant) & {NUM_REQ{stg_rdy}};

   always_ff @(posedge Clk) begin
      if (Rst || Clear) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         DataOut     <= '0;
         DataOutSrc  <= '0;
         DataOutLast <= 1'b0;
         DataOutVld  <= 1'b0;
      end else begin
         if (accept) begin
            if (sel_last) begin
               state <= IDLE;
               ptr   <= ptr_next;
            end else if (state == IDLE) begin
               state <= LOCKED;
               owner <= sel;
            end
         end
         if (stg_rdy) begin
            DataOutVld <= accept;
            if (accept) begin
               DataOut     <= data_arr[sel];
               DataOutSrc  <= sel;
               DataOutLast <= sel_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter with a small packet-generating requester model.
module tb_vr_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic                 Rst, Clear, DataOutRdy;
   logic [NR*DW-1:0]     ReqData;
   logic [NR-1:0]        ReqVld, ReqLast, ReqRdy;
   logic [DW-1:0]        DataOut;
   logic [IW-1:0]        DataOutSrc;
   logic                 DataOutLast, DataOutVld, Busy;

   vr_rr_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Clear       (Clear),
      .ReqData     (ReqData),
      .ReqVld      (ReqVld),
      .ReqLast     (ReqLast),
      .ReqRdy      (ReqRdy),
      .DataOut     (DataOut),
      .DataOutSrc  (DataOutSrc),
      .DataOutLast (DataOutLast),
      .DataOutVld  (DataOutVld),
      .DataOutRdy  (DataOutRdy),
      .Busy        (Busy)
   );

   int checks = 0;
   int errors = 0;

   // Requester model: pkts packets of plen beats each; beat data = i*32 + 16 + cnt.
   int pkts[NR], plen[NR], b[NR], cnt[NR];
   bit hold[NR];
   int q_src[$], q_data[$], q_last[$];
   logic [NR-1:0]    p_vld, p_rdy, p_last;
   logic [NR*DW-1:0] p_data;
   bit               p_rst = 1'b1;

   task automatic apply();
      for (int i = 0; i < NR; i++) begin
         ReqVld[i]           = !hold[i] && (pkts[i] > 0);
         ReqLast[i]          = (b[i] == plen[i] - 1);
         ReqData[i*DW +: DW] = 8'(i*32 + 16 + cnt[i]);
      end
   endtask

   task automatic settle();
      apply();
      #1;
   endtask

   // Inputs are stable until the next rising edge, so sampling here sees the pre-edge handshake.
   task automatic cycle();
      logic [NR-1:0] acc;
      bit rst_now;
      rst_now = Rst | Clear;
      acc     = ReqVld & ReqRdy;
      if (!rst_now && !p_rst) begin
         for (int i = 0; i < NR; i++) begin
            if (p_vld[i] && !p_rdy[i]) begin
               checks++;
               if (ReqVld[i] !== 1'b1 || ReqLast[i] !== p_last[i] ||
                   ReqData[i*DW +: DW] !== p_data[i*DW +: DW]) begin
                  errors++;
                  $display("FAIL req_contract req%0d: vld=%b data=%0d, want vld=1 data=%0d",
                           i, ReqVld[i], ReqData[i*DW +: DW], p_data[i*DW +: DW]);
               end
            end
         end
      end
      p_vld  = ReqVld;
      p_rdy  = ReqRdy;
      p_last = ReqLast;
      p_data = ReqData;
      p_rst  = rst_now;
      if (!rst_now && DataOutVld === 1'b1 && DataOutRdy === 1'b1) begin
         q_src.push_back(int'(DataOutSrc));
         q_data.push_back(int'(DataOut));
         q_last.push_back(int'(DataOutLast));
      end
      @(posedge Clk);
      @(negedge Clk);
      for (int i = 0; i < NR; i++) begin
         if (acc[i] === 1'b1) begin
            cnt[i]++;
            if (b[i] == plen[i] - 1) begin
               b[i] = 0;
               pkts[i]--;
            end else begin
               b[i]++;
            end
         end
      end
      settle();
   endtask

   task automatic reset_dut();
      Rst        = 1'b1;
      Clear      = 1'b0;
      DataOutRdy = 1'b1;
      for (int i = 0; i < NR; i++) begin
         pkts[i] = 0; plen[i] = 0; b[i] = 0; cnt[i] = 0; hold[i] = 1'b0;
      end
      settle();
      cycle();
      cycle();
      Rst = 1'b0;
      settle();
      q_src.delete(); q_data.delete(); q_last.delete();
   endtask

   task automatic test_reset();
      reset_dut();
      checks++; if (DataOutVld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", DataOutVld); end
      checks++; if (DataOut !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", DataOut); end
      checks++; if (DataOutSrc !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", DataOutSrc); end
      checks++; if (DataOutLast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", DataOutLast); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (ReqRdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b want 0000", ReqRdy); end
   endtask

   task automatic test_rr_single();
      reset_dut();
      for (int i = 0; i < NR; i++) begin pkts[i] = 2; plen[i] = 1; end
      settle();
      for (int k = 0; k < 8; k++) begin
         cycle();
         checks++;
         if (DataOutVld !== 1'b1 || int'(DataOutSrc) !== k % 4 ||
             int'(DataOut) !== (k % 4) * 32 + 16 + k / 4 || DataOutLast !== 1'b1) begin
            errors++;
            $display("FAIL rr_beat%0d: vld=%b src=%0d data=%0d last=%b, want vld=1 src=%0d data=%0d last=1",
                     k, DataOutVld, DataOutSrc, DataOut, DataOutLast, k % 4, (k % 4) * 32 + 16 + k / 4);
         end
      end
      cycle();
      checks++; if (DataOutVld !== 1'b0) begin errors++; $display("FAIL rr_drain_vld: got %b want 0", DataOutVld); end
   endtask

   task automatic test_packet_lock();
      logic [NR-1:0] exp_rdy[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      int exp_src[4]  = '{0, 0, 0, 1};
      int exp_last[4] = '{0, 0, 1, 1};
      int exp_busy[4] = '{1, 1, 0, 0};
      reset_dut();
      pkts[0] = 1; plen[0] = 3;
      pkts[1] = 1; plen[1] = 1;
      settle();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ReqRdy !== exp_rdy[k]) begin
            errors++; $display("FAIL lock_rdy%0d: got %b want %b", k, ReqRdy, exp_rdy[k]);
         end
         cycle();
         checks++;
         if (int'(DataOutSrc) !== exp_src[k] || int'(DataOutLast) !== exp_last[k] ||
             int'(Busy) !== exp_busy[k] || DataOutVld !== 1'b1) begin
            errors++;
            $display("FAIL lock_beat%0d: src=%0d last=%b busy=%b vld=%b, want src=%0d last=%0d busy=%0d vld=1",
                     k, DataOutSrc, DataOutLast, Busy, DataOutVld, exp_src[k], exp_last[k], exp_busy[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int exp_data[4] = '{16, 17, 18, 19};
      int exp_last[4] = '{0, 0, 0, 1};
      reset_dut();
      pkts[0] = 1; plen[0] = 4;
      settle();
      cycle();
      DataOutRdy = 1'b0;
      settle();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (ReqRdy !== 4'b0000 || DataOutVld !== 1'b1 || DataOut !== 8'd16 ||
             DataOutSrc !== 2'd0 || DataOutLast !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: rdy=%b vld=%b data=%0d src=%0d last=%b, want rdy=0000 vld=1 data=16 src=0 last=0",
                     k, ReqRdy, DataOutVld, DataOut, DataOutSrc, DataOutLast);
         end
         cycle();
      end
      DataOutRdy = 1'b1;
      settle();
      for (int k = 0; k < 6; k++) cycle();
      checks++;
      if (q_data.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d beats want 4", q_data.size()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= q_data.size() || q_data[k] !== exp_data[k] || q_last[k] !== exp_last[k] || q_src[k] !== 0) begin
            errors++;
            $display("FAIL bp_beat%0d: mismatch in beat, want data=%0d last=%0d src=0", k, exp_data[k], exp_last[k]);
         end
      end
   endtask

   task automatic test_owner_stall();
      int exp_src[5]  = '{2, 2, 2, 2, 3};
      int exp_data[5] = '{80, 81, 82, 83, 112};
      int exp_last[5] = '{0, 0, 0, 1, 1};
      reset_dut();
      pkts[2] = 1; plen[2] = 4;
      pkts[3] = 1; plen[3] = 1;
      settle();
      checks++; if (ReqRdy !== 4'b0100) begin errors++; $display("FAIL stall_first_rdy: got %b want 0100", ReqRdy); end
      cycle();
      hold[2] = 1'b1;
      settle();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (Busy !== 1'b1 || ReqRdy !== 4'b0100) begin
            errors++; $display("FAIL stall_lock%0d: busy=%b rdy=%b, want busy=1 rdy=0100", k, Busy, ReqRdy);
         end
         cycle();
      end
      hold[2] = 1'b0;
      settle();
      for (int k = 0; k < 6; k++) cycle();
      checks++;
      if (q_src.size() !== 5) begin errors++; $display("FAIL stall_count: got %0d beats want 5", q_src.size()); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (k >= q_src.size() || q_src[k] !== exp_src[k] || q_data[k] !== exp_data[k] || q_last[k] !== exp_last[k]) begin
            errors++;
            $display("FAIL stall_beat%0d: mismatch in beat, want src=%0d data=%0d last=%0d",
                     k, exp_src[k], exp_data[k], exp_last[k]);
         end
      end
   endtask

   task automatic test_clear();
      reset_dut();
      pkts[2] = 1; plen[2] = 1;
      settle();
      cycle();
      pkts[0] = 1; plen[0] = 4;
      settle();
      checks++; if (ReqRdy !== 4'b0001) begin errors++; $display("FAIL clr_pre_rdy: got %b want 0001", ReqRdy); end
      cycle();
      checks++;
      if (Busy !== 1'b1 || DataOutVld !== 1'b1 || DataOutSrc !== 2'd0) begin
         errors++; $display("FAIL clr_locked: busy=%b vld=%b src=%0d, want 1 1 0", Busy, DataOutVld, DataOutSrc);
      end
      Clear   = 1'b1;
      hold[0] = 1'b1;
      settle();
      cycle();
      Clear   = 1'b0;
      pkts[0] = 0; b[0] = 0; hold[0] = 1'b0;
      pkts[1] = 1; plen[1] = 2;
      pkts[3] = 1; plen[3] = 1;
      settle();
      checks++;
      if (DataOutVld !== 1'b0 || Busy !== 1'b0 || ReqRdy !== 4'b0010) begin
         errors++; $display("FAIL clr_after: vld=%b busy=%b rdy=%b, want vld=0 busy=0 rdy=0010", DataOutVld, Busy, ReqRdy);
      end
      cycle();
      checks++;
      if (Busy !== 1'b1 || DataOutVld !== 1'b1 || DataOutSrc !== 2'd1 || DataOut !== 8'd48) begin
         errors++; $display("FAIL clr_new1: busy=%b vld=%b src=%0d data=%0d, want 1 1 1 48", Busy, DataOutVld, DataOutSrc, DataOut);
      end
      cycle();
      checks++;
      if (DataOutSrc !== 2'd1 || DataOutLast !== 1'b1 || DataOut !== 8'd49 || Busy !== 1'b0) begin
         errors++; $display("FAIL clr_new2: src=%0d last=%b data=%0d busy=%b, want 1 1 49 0", DataOutSrc, DataOutLast, DataOut, Busy);
      end
      cycle();
      checks++;
      if (DataOutSrc !== 2'd3 || DataOut !== 8'd112 || DataOutLast !== 1'b1) begin
         errors++; $display("FAIL clr_next: src=%0d data=%0d last=%b, want 3 112 1", DataOutSrc, DataOut, DataOutLast);
      end
   endtask

   task automatic test_wrap();
      int exp_src[7]  = '{2, 3, 3, 0, 0, 2, 0};
      int exp_data[7] = '{80, 112, 113, 16, 17, 81, 18};
      int exp_last[7] = '{1, 0, 1, 0, 1, 1, 1};
      reset_dut();
      pkts[2] = 1; plen[2] = 1;
      settle();
      cycle();
      pkts[0] = 1; plen[0] = 2;
      pkts[3] = 1; plen[3] = 2;
      settle();
      checks++; if (ReqRdy !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b want 1000", ReqRdy); end
      for (int k = 0; k < 4; k++) cycle();
      pkts[0] = 1; plen[0] = 1;
      pkts[2] = 1; plen[2] = 1;
      settle();
      checks++; if (ReqRdy !== 4'b0100) begin errors++; $display("FAIL wrap_ptr1: got %b want 0100", ReqRdy); end
      for (int k = 0; k < 3; k++) cycle();
      checks++;
      if (q_src.size() !== 7) begin errors++; $display("FAIL wrap_count: got %0d beats want 7", q_src.size()); end
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (k >= q_src.size() || q_src[k] !== exp_src[k] || q_data[k] !== exp_data[k] || q_last[k] !== exp_last[k]) begin
            errors++;
            $display("FAIL wrap_beat%0d: mismatch in beat, want src=%0d data=%0d last=%0d",
                     k, exp_src[k], exp_data[k], exp_last[k]);
         end
      end
   endtask

   initial begin
      Rst        = 1'b1;
      Clear      = 1'b0;
      DataOutRdy = 1'b1;
      ReqVld     = '0;
      ReqLast    = '0;
      ReqData    = '0;
      test_reset();
      test_rr_single();
      test_packet_lock();
      test_backpressure();
      test_owner_stall();
      test_clear();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
